// File: rtl/adc_capture_buf.sv
// adc_capture_buf
//   Captures a circular window of unsigned ADC samples around a trigger event
//   into an internal RAM, then streams the frame out oldest-first.
//
//   Capture: arm latches trig_mode/trig_level/pre_trig and enters PRE. PRE
//   collects pre_trig samples. WAIT_TRIG keeps writing circularly until the
//   selected trigger fires. POST collects the rest of the DEPTH-sample frame.
//   Readout: rd_start in DONE streams DEPTH words over valid/ready.
//
// Ports
//   sys_clk, sys_rst        : clock, asynchronous active-high reset
//   sample_valid, adc_data  : sample strobe and sample value
//   arm, abort              : start capture / return to IDLE (abort wins)
//   trig_mode, trig_level   : 00 immediate, 01 rising, 10 falling, 11 external
//   ext_trig                : external trigger, looked at on sample_valid
//   pre_trig                : samples kept ahead of the trigger sample
//   rd_start, rd_ready      : begin readout / consumer ready
//   rd_valid, rd_data, rd_last : readout stream, rd_last on the final word
//   busy, done, trig_addr   : status and RAM address of the trigger sample
module adc_capture_buf #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              ext_trig,
  input  logic [ADDR_W-1:0] pre_trig,
  input  logic              rd_start,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4,
    S_READ = 3'd5
  } state_t;

  // Crossing modes need a previous sample; prev_ok is low for the first sample after arm.
  function automatic logic trig_hit(input logic [1:0] mode, input logic [DATA_W-1:0] prev,
                                    input logic prev_ok, input logic [DATA_W-1:0] cur,
                                    input logic [DATA_W-1:0] lvl, input logic ext);
    logic hit;
    case (mode)
      2'b00:   hit = 1'b1;
      2'b01:   hit = prev_ok && (prev < lvl) && (cur >= lvl);
      2'b10:   hit = prev_ok && (prev >= lvl) && (cur < lvl);
      2'b11:   hit = ext;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   level_q, level_d;
  logic [ADDR_W-1:0]   pre_q, pre_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
  logic                ram_vld_q, ram_vld_d;
  logic                ram_last_q, ram_last_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_last_q, rd_last_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   ram_q;

  logic                capturing_s, arm_ok_s, mem_we_s, mem_re_s;
  logic                out_load_s, out_fire_s, hit_s;
  logic [ADDR_W-1:0]   post_cnt_s;

  // Next-state logic for capture control and the two-stage readout pipeline.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    level_d     = level_q;
    pre_d       = pre_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    trig_addr_d = trig_addr_q;
    rd_addr_d   = rd_addr_q;
    issue_cnt_d = issue_cnt_q;
    ram_vld_d   = ram_vld_q;
    ram_last_d  = ram_last_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    rd_last_d   = rd_last_q;

    capturing_s = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    arm_ok_s    = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
    mem_we_s    = capturing_s && sample_valid && !abort;
    hit_s       = trig_hit(mode_q, prev_q, prev_vld_q, adc_data, level_q, ext_trig);
    // DEPTH-1-pre_trig is the bitwise complement of pre_trig.
    post_cnt_s  = ~pre_q;

    // The RAM stage only fetches when its word can move on, so a stalled
    // consumer freezes both stages and no separate skid buffer is needed.
    out_fire_s  = rd_valid_q && rd_ready;
    out_load_s  = (state_q == S_READ) && ram_vld_q && (!rd_valid_q || rd_ready);
    mem_re_s    = (state_q == S_READ) && !abort && (!ram_vld_q || out_load_s) &&
                  (issue_cnt_q != (ADDR_W+1)'(DEPTH));

    if (mem_we_s) begin
      wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
      prev_d     = adc_data;
      prev_vld_d = 1'b1;
    end else begin
      wr_ptr_d   = wr_ptr_q;
    end

    if (mem_re_s) begin
      rd_addr_d   = rd_addr_q + ADDR_W'(1);
      issue_cnt_d = issue_cnt_q + (ADDR_W+1)'(1);
      ram_vld_d   = 1'b1;
      ram_last_d  = (issue_cnt_q == (ADDR_W+1)'(DEPTH-1));
    end else if (out_load_s) begin
      ram_vld_d   = 1'b0;
    end else begin
      ram_vld_d   = ram_vld_q;
    end

    if (out_load_s) begin
      rd_valid_d = 1'b1;
      rd_data_d  = ram_q;
      rd_last_d  = ram_last_q;
    end else if (out_fire_s) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end else begin
      rd_valid_d = rd_valid_q;
    end

    if (abort) begin
      state_d    = S_IDLE;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      ram_vld_d  = 1'b0;
    end else if (arm_ok_s) begin
      state_d    = S_PRE;
      mode_d     = trig_mode;
      level_d    = trig_level;
      pre_d      = pre_trig;
      cnt_d      = '0;
      prev_vld_d = 1'b0;
    end else begin
      case (state_q)
        S_PRE: begin
          if (pre_q == '0) begin
            state_d = S_WAIT;
          end else if (sample_valid) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if ((cnt_q + ADDR_W'(1)) == pre_q) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_PRE;
            end
          end else begin
            state_d = S_PRE;
          end
        end
        S_WAIT: begin
          if (sample_valid && hit_s) begin
            trig_addr_d = wr_ptr_q;
            cnt_d       = post_cnt_s;
            if (post_cnt_s == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_POST;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_POST: begin
          if (sample_valid) begin
            cnt_d = cnt_q - ADDR_W'(1);
            if (cnt_q == ADDR_W'(1)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_POST;
            end
          end else begin
            state_d = S_POST;
          end
        end
        S_DONE: begin
          if (rd_start) begin
            state_d     = S_READ;
            rd_addr_d   = trig_addr_q - pre_q;
            issue_cnt_d = '0;
            ram_vld_d   = 1'b0;
            ram_last_d  = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
        S_READ: begin
          if (out_fire_s && rd_last_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_READ;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_PRE) || (state_d == S_WAIT) ||
             (state_d == S_POST) || (state_d == S_READ);
    done_d = (state_d == S_DONE);
  end

  // Control, status and readout output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      mode_q      <= 2'b00;
      level_q     <= '0;
      pre_q       <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      trig_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_addr_q   <= '0;
      issue_cnt_q <= '0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      level_q     <= level_d;
      pre_q       <= pre_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      trig_addr_q <= trig_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_addr_q   <= rd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
    end
  end

  // Sample RAM: capture write port plus one registered read port; contents are not reset.
  always_ff @(posedge sys_clk) begin
    if (mem_we_s) begin
      mem[wr_ptr_q] <= adc_data;
    end
    if (mem_re_s) begin
      ram_q <= mem[rd_addr_q];
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_addr = trig_addr_q;

endmodule
